signed_divider: RTL and testbench

Multi-cycle signed (two's-complement) integer divider producing quotient and remainder of a SIZE-bit dividend by a SIZE-bit divisor.

- Inverse companion of the Booth multiplier in the arithmetic library.
- Same serial operand load: dividend, then divisor, over a shared `data_in` bus. Same `start`/`done` handshake.
- Uses restoring division on operand magnitudes, followed by a one-cycle sign fix-up.

---
 rtl/signed_divider_pkg.sv | 31 +++
 rtl/signed_divider_ctrl.sv | 67 ++++++
 rtl/signed_divider.sv | 135 +++++++++++++
 tb/tb_signed_divider.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/signed_divider_pkg.sv
// Shared definitions for the signed restoring divider: state encoding,
// default operand width and the layout of the packed result word.
package signed_divider_pkg;

    localparam int SIZE_DEFAULT = 8;

    // Controller state encoding (3 bits)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_LOAD_B = 3'd2;
    localparam logic [2:0] ST_ITER   = 3'd3;
    localparam logic [2:0] ST_FIX    = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD_A = ST_LOAD_A,
        S_LOAD_B = ST_LOAD_B,
        S_ITER   = ST_ITER,
        S_FIX    = ST_FIX,
        S_DONE   = ST_DONE
    } state_t;

    // data_out layout: quotient in the low half, remainder in the high half
    localparam int QUOT_OFS = 0;

    function automatic int rem_ofs(input int size);
        return size;
    endfunction

endpackage

// File: rtl/signed_divider_ctrl.sv
// Controller for the signed divider: sequences operand load, SIZE
// restoring iterations and the sign fix-up, and emits datapath strobes.
module signed_divider_ctrl
    import signed_divider_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic load_a,
    output logic load_b,
    output logic iter,
    output logic fix,
    output logic done
);

    localparam int CW = $clog2(SIZE + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(SIZE);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    state_t         state_r;
    logic [CW-1:0]  count_r;

    // Next-state and iteration counter; reset wins over every transition
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            count_r <= CNT_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) state_r <= S_LOAD_A;
                    else       state_r <= S_IDLE;
                end
                S_LOAD_A: state_r <= S_LOAD_B;
                S_LOAD_B: begin
                    state_r <= S_ITER;
                    count_r <= CNT_INIT;
                end
                S_ITER: begin
                    count_r <= count_r - CNT_ONE;
                    if (count_r == CNT_ONE) state_r <= S_FIX;
                    else                    state_r <= S_ITER;
                end
                S_FIX: state_r <= S_DONE;
                S_DONE: begin
                    if (start) state_r <= S_LOAD_A;
                    else       state_r <= S_DONE;
                end
                default: begin
                    state_r <= S_IDLE;
                    count_r <= CNT_ZERO;
                end
            endcase
        end
    end

    // Strobes are pure decodes of the state register
    assign load_a = (state_r == S_LOAD_A);
    assign load_b = (state_r == S_LOAD_B);
    assign iter   = (state_r == S_ITER);
    assign fix    = (state_r == S_FIX);
    assign done   = (state_r == S_DONE);

endmodule

// File: rtl/signed_divider.sv
// Multi-cycle signed divider: restoring division on operand magnitudes
// followed by a one-cycle sign fix-up. Operands arrive serially on data_in.
module signed_divider
    import signed_divider_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SIZE-1:0]   data_in,
    output logic [2*SIZE-1:0] data_out,
    output logic              done,
    output logic              dz,
    output logic              ovf
);

    localparam int REM_OFS = rem_ofs(SIZE);
    localparam logic [SIZE-1:0] ONE_C      = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic [SIZE-1:0] ALL_ONES_C = {SIZE{1'b1}};
    localparam logic [SIZE-1:0] MOST_NEG_C = {1'b1, {(SIZE-1){1'b0}}};

    // Two's-complement negation shared by operand and result sign handling
    function automatic logic [SIZE-1:0] neg(input logic [SIZE-1:0] v);
        return ~v + ONE_C;
    endfunction

    logic load_a_s, load_b_s, iter_s, fix_s;

    signed_divider_ctrl #(.SIZE(SIZE)) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .load_a (load_a_s),
        .load_b (load_b_s),
        .iter   (iter_s),
        .fix    (fix_s),
        .done   (done)
    );

    logic              sign_a_r, sign_b_r, b_zero_r, b_m1_r;
    logic [SIZE-1:0]   abs_a_r, abs_b_r, raw_a_r;
    logic [SIZE:0]     r_r;
    logic [SIZE-1:0]   q_r;
    logic [2*SIZE-1:0] data_out_r;
    logic              dz_r, ovf_r;

    logic [SIZE+1:0]   trial_s;
    logic [SIZE:0]     r_sh_s;
    logic [SIZE-1:0]   quot_s, rem_s;
    logic              ovf_s;
    logic [2*SIZE-1:0] result_s;

    // Trial subtraction of one restoring step and the signed result
    always_comb begin
        r_sh_s  = {r_r[SIZE-1:0], q_r[SIZE-1]};
        trial_s = {r_r, q_r[SIZE-1]} - {2'b00, abs_b_r};
        if (b_zero_r) begin
            quot_s = ALL_ONES_C;
            rem_s  = raw_a_r;
        end else begin
            quot_s = (sign_a_r ^ sign_b_r) ? neg(q_r) : q_r;
            rem_s  = sign_a_r ? neg(r_r[SIZE-1:0]) : r_r[SIZE-1:0];
        end
        ovf_s    = !b_zero_r && (raw_a_r == MOST_NEG_C) && b_m1_r;
        result_s = {(2*SIZE){1'b0}};
        result_s[REM_OFS  +: SIZE] = rem_s;
        result_s[QUOT_OFS +: SIZE] = quot_s;
    end

    // Operand capture: dividend on load_a, divisor on load_b
    always_ff @(posedge clk) begin
        if (reset) begin
            sign_a_r <= 1'b0;
            abs_a_r  <= {SIZE{1'b0}};
            raw_a_r  <= {SIZE{1'b0}};
            sign_b_r <= 1'b0;
            abs_b_r  <= {SIZE{1'b0}};
            b_zero_r <= 1'b0;
            b_m1_r   <= 1'b0;
        end else if (load_a_s) begin
            sign_a_r <= data_in[SIZE-1];
            abs_a_r  <= data_in[SIZE-1] ? neg(data_in) : data_in;
            raw_a_r  <= data_in;
        end else if (load_b_s) begin
            sign_b_r <= data_in[SIZE-1];
            abs_b_r  <= data_in[SIZE-1] ? neg(data_in) : data_in;
            b_zero_r <= (data_in == {SIZE{1'b0}});
            b_m1_r   <= (data_in == ALL_ONES_C);
        end else begin
            sign_a_r <= sign_a_r;
        end
    end

    // Partial remainder / quotient shift register for the restoring loop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_r <= {(SIZE+1){1'b0}};
            q_r <= {SIZE{1'b0}};
        end else if (load_b_s) begin
            r_r <= {(SIZE+1){1'b0}};
            q_r <= abs_a_r;
        end else if (iter_s) begin
            if (!trial_s[SIZE+1]) begin
                r_r <= trial_s[SIZE:0];
                q_r <= {q_r[SIZE-2:0], 1'b1};
            end else begin
                r_r <= r_sh_s;
                q_r <= {q_r[SIZE-2:0], 1'b0};
            end
        end else begin
            r_r <= r_r;
        end
    end

    // Result and flags are written only in the fix-up cycle and held otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_r <= {(2*SIZE){1'b0}};
            dz_r       <= 1'b0;
            ovf_r      <= 1'b0;
        end else if (fix_s) begin
            data_out_r <= result_s;
            dz_r       <= b_zero_r;
            ovf_r      <= ovf_s;
        end else begin
            data_out_r <= data_out_r;
        end
    end

    assign data_out = data_out_r;
    assign dz       = dz_r;
    assign ovf      = ovf_r;

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider: directed cases plus random
// operands compared against plain integer division semantics.
module tb_signed_divider;
    import signed_divider_pkg::*;

    localparam int SIZE = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [SIZE-1:0]   data_in;
    logic [2*SIZE-1:0] data_out;
    logic              done, dz, ovf;

    int total = 0;
    int bad   = 0;
    logic [2*SIZE-1:0] last_out;

    always #5 clk = ~clk;

    signed_divider #(.SIZE(SIZE)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .data_out (data_out),
        .done     (done),
        .dz       (dz),
        .ovf      (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: truncating signed division, remainder follows dividend
    function automatic void model(input logic signed [7:0] a, input logic signed [7:0] b,
                                  output logic [15:0] d, output logic edz, output logic eovf);
        int ai, bi, q, r;
        ai = a;
        bi = b;
        edz  = 1'b0;
        eovf = 1'b0;
        if (bi == 0) begin
            q = -1; r = ai; edz = 1'b1;
        end else if (ai == -128 && bi == -1) begin
            q = 128; r = 0; eovf = 1'b1;
        end else begin
            q = ai / bi; r = ai % bi;
        end
        d = {r[7:0], q[7:0]};
    endfunction

    task automatic run_op(input logic signed [7:0] a, input logic signed [7:0] b,
                          input logic hold, input string tag);
        logic [15:0] ed;
        logic        edz, eovf;
        int          lat;
        model(a, b, ed, edz, eovf);
        start   = 1'b1;
        data_in = 8'($urandom);
        @(posedge clk); #1;                       // edge 0
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        start   = hold;
        data_in = a;
        @(posedge clk); #1;                       // edge 1
        chk({tag, "_prev_held"}, 32'(data_out), 32'(last_out));
        data_in = b;
        @(posedge clk); #1;                       // edge 2
        lat = 2;
        while (done !== 1'b1 && lat < 40) begin
            start   = hold ? 1'b1 : 1'($urandom_range(0, 1));
            data_in = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd11);
        chk({tag, "_data_out"}, 32'(data_out), 32'(ed));
        chk({tag, "_dz"}, 32'(dz), 32'(edz));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        last_out = ed;
        if (!hold) start = 1'b0;
    endtask

    initial begin
        logic signed [7:0] ra, rb;
        reset    = 1'b1;
        start    = 1'b0;
        data_in  = 8'h00;
        last_out = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dz", 32'(dz), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_state", 32'(u_dut.u_ctrl.state_r), 32'(ST_IDLE));
        chk("rst_count", 32'(u_dut.u_ctrl.count_r), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Sign combinations and corner cases
        run_op(8'h64, 8'h07, 1'b0, "p100_p7");
        chk("p100_p7_const", 32'(data_out), 32'h020E);
        run_op(8'h9C, 8'h07, 1'b0, "m100_p7");
        chk("m100_p7_const", 32'(data_out), 32'hFEF2);
        run_op(8'h64, 8'hF9, 1'b0, "p100_m7");
        chk("p100_m7_const", 32'(data_out), 32'h02F2);
        run_op(8'h9C, 8'hF9, 1'b0, "m100_m7");
        chk("m100_m7_const", 32'(data_out), 32'hFE0E);
        run_op(8'h80, 8'hFF, 1'b0, "ovf");
        chk("ovf_const", 32'(data_out), 32'h0080);
        run_op(8'h06, 8'h03, 1'b0, "after_ovf");
        run_op(8'h05, 8'h00, 1'b0, "dz_pos");
        chk("dz_pos_const", 32'(data_out), 32'h05FF);
        run_op(8'hFB, 8'h00, 1'b0, "dz_neg");
        chk("dz_neg_const", 32'(data_out), 32'hFBFF);

        // Reset in the middle of the iteration loop
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        data_in = 8'd50;
        @(posedge clk); #1;
        data_in = 8'd3;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_count", 32'(u_dut.u_ctrl.count_r), 32'd4);
        chk("mid_state", 32'(u_dut.u_ctrl.state_r), 32'(ST_ITER));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_state", 32'(u_dut.u_ctrl.state_r), 32'(ST_IDLE));
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_data_out", 32'(data_out), 32'd0);
        chk("mid_rst_dz", 32'(dz), 32'd0);
        reset    = 1'b0;
        last_out = 16'h0000;
        @(posedge clk); #1;
        run_op(8'h09, 8'h02, 1'b0, "after_rst");
        chk("after_rst_const", 32'(data_out), 32'h0104);

        // Back-to-back with start held high
        run_op(8'h7F, 8'h01, 1'b1, "b2b_1");
        run_op(8'h80, 8'h02, 1'b1, "b2b_2");
        chk("b2b_2_const", 32'(data_out), 32'h00C0);
        run_op(8'h01, 8'h80, 1'b1, "b2b_3");
        chk("b2b_3_const", 32'(data_out), 32'h0100);
        start = 1'b0;
        @(posedge clk); #1;

        // Random operands with bias toward the special divisors
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 9) == 0) ? 8'h80 : 8'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 8'h00;
                1:       rb = 8'hFF;
                default: rb = 8'($urandom);
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), "rand");
        end
        start = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
